// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the RV32I register file: three sources, one-entry holding
// register each, round-robin drain into a registered one-hot write stage.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [2:0]        req_valid_i,
  output logic [2:0]        req_ready_o,
  input  logic [4:0]        req_rd0_i,
  input  logic [4:0]        req_rd1_i,
  input  logic [4:0]        req_rd2_i,
  input  logic [DATA_W-1:0] req_data0_i,
  input  logic [DATA_W-1:0] req_data1_i,
  input  logic [DATA_W-1:0] req_data2_i,
  output logic [31:0]       wb_we_o,
  output logic [4:0]        wb_rd_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [31:0]       busy_o
);

  logic [2:0]        held_q;
  logic [4:0]        rdHeld_q   [3];
  logic [DATA_W-1:0] dataHeld_q [3];
  logic [1:0]        ptr_q, ptr_d;
  logic [31:0]       wbWe_q, wbWe_d;
  logic [4:0]        wbRd_q;
  logic [DATA_W-1:0] wbData_q;

  logic [4:0]        reqRd   [3];
  logic [DATA_W-1:0] reqData [3];
  logic [1:0]        order   [3];
  logic [2:0]        grant;
  logic [1:0]        gntIdx;
  logic              gntValid;
  logic [4:0]        gntRd;

  assign reqRd[0]   = req_rd0_i;
  assign reqRd[1]   = req_rd1_i;
  assign reqRd[2]   = req_rd2_i;
  assign reqData[0] = req_data0_i;
  assign reqData[1] = req_data1_i;
  assign reqData[2] = req_data2_i;

  // Round-robin search starting at the pointer; first held port wins
  always_comb begin
    case (ptr_q)
      2'd1:    order = '{2'd1, 2'd2, 2'd0};
      2'd2:    order = '{2'd2, 2'd0, 2'd1};
      default: order = '{2'd0, 2'd1, 2'd2};
    endcase
    gntValid = 1'b0;
    gntIdx   = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (!gntValid && held_q[order[k]]) begin
        gntValid = 1'b1;
        gntIdx   = order[k];
      end
    end
    grant = gntValid ? (3'b001 << gntIdx) : 3'b000;
  end

  always_comb begin
    gntRd  = rdHeld_q[gntIdx];
    ptr_d  = ptr_q;
    wbWe_d = 32'd0;
    if (gntValid) begin
      ptr_d = (gntIdx == 2'd2) ? 2'd0 : gntIdx + 2'd1;
      // x0 consumes its slot but never raises a write enable
      if (gntRd != 5'd0) wbWe_d = 32'd1 << gntRd;
    end
  end

  assign req_ready_o = {3{~rst_i}} & (~held_q | grant);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      held_q   <= 3'b000;
      ptr_q    <= 2'd0;
      wbWe_q   <= 32'd0;
      wbRd_q   <= 5'd0;
      wbData_q <= '0;
      for (int i = 0; i < 3; i++) begin
        rdHeld_q[i]   <= 5'd0;
        dataHeld_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (req_valid_i[i] && req_ready_o[i]) begin
          held_q[i]     <= 1'b1;
          rdHeld_q[i]   <= reqRd[i];
          dataHeld_q[i] <= reqData[i];
        end else if (grant[i]) begin
          held_q[i] <= 1'b0;
        end
      end
      ptr_q  <= ptr_d;
      wbWe_q <= wbWe_d;
      if (gntValid) begin
        wbRd_q   <= gntRd;
        wbData_q <= dataHeld_q[gntIdx];
      end
    end
  end

  // Scoreboard covers both the holding registers and the write stage
  always_comb begin
    busy_o = wbWe_q;
    for (int i = 0; i < 3; i++) begin
      if (held_q[i]) busy_o[rdHeld_q[i]] = 1'b1;
    end
    busy_o[0] = 1'b0;
  end

  assign wb_we_o   = wbWe_q;
  assign wb_rd_o   = wbRd_q;
  assign wb_data_o = wbData_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs change on the falling edge,
// outputs are compared on the falling edge against hand-computed values.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  reqValid;
  logic [2:0]  reqReady;
  logic [4:0]  reqRd0, reqRd1, reqRd2;
  logic [31:0] reqData0, reqData1, reqData2;
  logic [31:0] wbWe;
  logic [4:0]  wbRd;
  logic [31:0] wbData;
  logic [31:0] busy;

  int errors = 0;
  int checks = 0;

  regfile_wb_arbiter #(.DATA_W(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (reqValid),
    .req_ready_o (reqReady),
    .req_rd0_i   (reqRd0),
    .req_rd1_i   (reqRd1),
    .req_rd2_i   (reqRd2),
    .req_data0_i (reqData0),
    .req_data1_i (reqData1),
    .req_data2_i (reqData2),
    .wb_we_o     (wbWe),
    .wb_rd_o     (wbRd),
    .wb_data_o   (wbData),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] valid,
                               input logic [4:0] rd0, input logic [31:0] d0,
                               input logic [4:0] rd1, input logic [31:0] d1,
                               input logic [4:0] rd2, input logic [31:0] d2);
    reqValid = valid;
    reqRd0 = rd0; reqData0 = d0;
    reqRd1 = rd1; reqData1 = d1;
    reqRd2 = rd2; reqData2 = d2;
  endtask

  logic [31:0] fairExp [7];
  int          idx0;
  logic        acc0, acc2;

  initial begin
    // Reset held for two edges with every port requesting
    rst = 1'b1;
    applyStimulus(3'b111, 5'd9, 32'h1, 5'd9, 32'h2, 5'd9, 32'h3);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_ready", {29'd0, reqReady}, 32'd0);
    checkOutput("rst_we",    wbWe, 32'd0);
    checkOutput("rst_busy",  busy, 32'd0);
    checkOutput("rst_wbrd",  {27'd0, wbRd}, 32'd0);
    checkOutput("rst_wbdata", wbData, 32'd0);

    // Three-way contention straight out of reset
    rst = 1'b0;
    applyStimulus(3'b111, 5'd1, 32'hAAAA_0001, 5'd2, 32'hAAAA_0002, 5'd3, 32'hAAAA_0003);
    #1;
    checkOutput("cont_ready", {29'd0, reqReady}, 32'h7);
    @(negedge clk);
    reqValid = 3'b000;
    checkOutput("cont_busy0", busy, 32'h0000_000E);
    checkOutput("cont_we0",   wbWe, 32'd0);
    @(negedge clk);
    checkOutput("cont_we1",   wbWe, 32'h0000_0002);
    checkOutput("cont_data1", wbData, 32'hAAAA_0001);
    checkOutput("cont_busy1", busy, 32'h0000_000E);
    @(negedge clk);
    checkOutput("cont_we2",   wbWe, 32'h0000_0004);
    checkOutput("cont_data2", wbData, 32'hAAAA_0002);
    checkOutput("cont_busy2", busy, 32'h0000_000C);
    @(negedge clk);
    checkOutput("cont_we3",   wbWe, 32'h0000_0008);
    checkOutput("cont_rd3",   {27'd0, wbRd}, 32'd3);
    checkOutput("cont_busy3", busy, 32'h0000_0008);
    @(negedge clk);
    checkOutput("cont_we4",   wbWe, 32'd0);
    checkOutput("cont_busy4", busy, 32'd0);
    checkOutput("cont_hold",  wbData, 32'hAAAA_0003);
    checkOutput("cont_ptr",   {30'd0, dut.ptr_q}, 32'd0);

    // Single write from the load port
    applyStimulus(3'b010, 5'd0, 32'd0, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'd0);
    @(negedge clk);
    reqValid = 3'b000;
    checkOutput("single_busy0", busy, 32'h0000_0020);
    checkOutput("single_we0",   wbWe, 32'd0);
    @(negedge clk);
    checkOutput("single_we1",   wbWe, 32'h0000_0020);
    checkOutput("single_data",  wbData, 32'hDEAD_BEEF);
    checkOutput("single_rd",    {27'd0, wbRd}, 32'd5);
    checkOutput("single_busy1", busy, 32'h0000_0020);
    @(negedge clk);
    checkOutput("single_we2",   wbWe, 32'd0);
    checkOutput("single_busy2", busy, 32'd0);

    // x0 write from the mul/div port still uses a grant slot
    applyStimulus(3'b100, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'h1234_5678);
    @(negedge clk);
    reqValid = 3'b000;
    checkOutput("x0_busy0", busy, 32'd0);
    @(negedge clk);
    checkOutput("x0_we",    wbWe, 32'd0);
    checkOutput("x0_busy1", busy, 32'd0);
    checkOutput("x0_data",  wbData, 32'h1234_5678);
    checkOutput("x0_ptr",   {30'd0, dut.ptr_q}, 32'd0);

    // Port 0 streams x10..x13 while port 2 holds one write to x20
    fairExp = '{32'd0, 32'h0000_0400, 32'h0010_0000, 32'h0000_0800,
                32'h0000_1000, 32'h0000_2000, 32'd0};
    idx0 = 0;
    applyStimulus(3'b101, 5'd10, 32'hC000_0000, 5'd0, 32'd0, 5'd20, 32'hB000_0020);
    for (int k = 0; k < 7; k++) begin
      acc0 = reqValid[0] & reqReady[0];
      acc2 = reqValid[2] & reqReady[2];
      @(negedge clk);
      if (acc2) reqValid[2] = 1'b0;
      if (acc0) begin
        idx0++;
        if (idx0 == 4) reqValid[0] = 1'b0;
        else begin
          reqRd0   = 5'(10 + idx0);
          reqData0 = 32'hC000_0000 + 32'(idx0);
        end
      end
      checkOutput($sformatf("fair_we%0d", k), wbWe, fairExp[k]);
    end
    checkOutput("fair_accepts", 32'(idx0), 32'd4);

    // Reset while ports 0 and 2 hold entries
    applyStimulus(3'b101, 5'd7, 32'h7777_7777, 5'd0, 32'd0, 5'd9, 32'h9999_9999);
    @(negedge clk);
    reqValid = 3'b000;
    checkOutput("mid_busy_pre", busy, 32'h0000_0280);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_we_rst",    wbWe, 32'd0);
    checkOutput("mid_busy_rst",  busy, 32'd0);
    checkOutput("mid_ready_rst", {29'd0, reqReady}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_we_after",   wbWe, 32'd0);
    checkOutput("mid_busy_after", busy, 32'd0);
    checkOutput("mid_ptr",        {30'd0, dut.ptr_q}, 32'd0);
    @(negedge clk);
    checkOutput("mid_we_after2",  wbWe, 32'd0);
    checkOutput("mid_ready_after", {29'd0, reqReady}, 32'h7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single register-file write port of the RV32I core among three writeback sources: port 0 (ALU/main writeback), port 1 (load unit) and port 2 (multiply/divide unit). Each source hands over one (rd, data) pair through a valid/ready handshake into a one-entry holding register. A round-robin scheduler drains the holding registers, one per cycle, into a registered write stage. That stage drives a decoded one-hot write-enable vector plus data to the register file. The block also exports a 32-bit busy scoreboard for hazard detection.

## Interface
- DATA_W, 32, width of writeback data.
- CLK  in  1  rising-edge clock, sole clock domain.
- RST  in  1  synchronous, active-high reset.
- REQ_VALID  in  3  per-port request valid; bit i = port i.
- REQ_READY  out  3  per-port ready; transfer when VALID[i] & READY[i] at a rising edge.
- REQ_RD0 / REQ_RD1 / REQ_RD2  in  5 each  destination register per port.
- REQ_DATA0 / REQ_DATA1 / REQ_DATA2  in  DATA_W each  write data per port.
- WB_WE  out  32  one-hot register write enable; bit r writes xr; bit 0 never set.
- WB_RD  out  5  index of register written this cycle (debug/trace).
- WB_DATA  out  DATA_W  data for the register selected by WB_WE.
- BUSY  out  32  bit r = 1 while a pending write to xr is held anywhere in the block; bit 0 always 0.

## Operation
- Holding register per port: HELD[i], RD_H[i], DATA_H[i]. Loaded on a REQ_VALID[i] & REQ_READY[i] edge.
- REQ_READY[i] = ~RST & (~HELD[i] | GRANT[i]). A port granted this cycle can accept a new entry at the same edge.
- Round-robin pointer PTR (0..2). GRANT is combinational: the first i with HELD[i] = 1, searching PTR, PTR+1, PTR+2 (mod 3). At most one grant per cycle.
- On a granted edge:
  - HELD[g] clears, unless reloaded at the same edge.
  - PTR <= (g+1) mod 3.
  - Write stage loads WB_RD = RD_H[g] and WB_DATA = DATA_H[g].
  - WB_WE = 5-to-32 one-hot decode of RD_H[g], forced to all-zero when RD_H[g] = 0.
- No grant: WB_WE <= 0. WB_RD and WB_DATA hold their previous values.
- PTR holds when there is no grant.
- A write to x0 is accepted and consumed normally and occupies its grant slot, but produces no WB_WE bit.
- BUSY[r] = OR over i of (HELD[i] & RD_H[i] == r), OR (WB_WE[r]); forced 0 for r = 0.
- The block gives no ordering between ports. Upstream must not issue a second write to xr while BUSY[r] = 1; behaviour in that case is not defined.
- Within a single port, writes leave in acceptance order.

## Timing
- Reset (RST high at an edge):
  - HELD = 000, PTR = 0.
  - WB_WE = 0, WB_RD = 0, WB_DATA = 0.
  - BUSY = 0, REQ_READY = 000 while RST is high.
- Reset mid-operation: all held and in-flight writes are dropped. No WB_WE pulse follows the reset edge.
- Latency:
  - Accept at edge t → HELD visible in cycle t+1.
  - If granted in cycle t+1, WB_WE is asserted for exactly cycle t+2.
  - The register file writes at the end of cycle t+2.
- Throughput: one write per cycle aggregate. A single streaming port with the others idle sustains one write per cycle, with REQ_READY held high.
- Contention: with all three ports held, each is served within 3 cycles. Worst-case wait from HELD to grant is 2 cycles.
- WB_WE is never multi-hot. It is a single-cycle pulse per grant; consecutive grants give consecutive pulses.
- BUSY[r] rises the cycle after the accepting edge. It falls the cycle after the WB_WE[r] pulse, unless re-held.

## Test plan
- Reset: assert RST for 2 cycles with all REQ_VALID high → REQ_READY = 000, WB_WE = 0, BUSY = 0. First accept happens on the first edge after RST falls.
- Single write: port 1 sends rd = 5, data = 0xDEADBEEF → WB_WE = 0x00000020 and WB_DATA = 0xDEADBEEF exactly 2 cycles after the accept edge. BUSY[5] is high for 2 cycles.
- Three-way contention from reset: all ports accept at once (rd = 1, 2, 3) → WB_WE pulses 0x2, 0x4, 0x8 on consecutive cycles (port order 0, 1, 2). PTR ends at 0.
- Round-robin fairness: port 0 streams continuously while port 2 holds one entry → port 2 is granted within 2 cycles, interleaved with port 0. Port 0 is never starved.
- x0 write: port 2 sends rd = 0, data = 0x12345678 → a grant slot is consumed, WB_WE stays 0, BUSY stays 0.
- Reset mid-operation: hold entries on ports 0 and 2, assert RST for 1 cycle → no WB_WE pulse afterwards, BUSY = 0, PTR = 0.
